// File: rtl/shrot_pkg.sv
// Shared types and widths for the shrot_sched shift/rotate scheduler.
package shrot_pkg;

  localparam int SHROT_W     = 32;
  localparam int SHROT_SEL_W = 5;
  localparam int SHROT_CNT_W = 3;
  localparam int SHROT_IDX_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic [SHROT_IDX_W-1:0] wrap_inc(input logic [SHROT_IDX_W-1:0] idx,
                                                      input int unsigned n);
    int unsigned nxt;
    nxt = (32'(idx) + 32'd1) % n;
    return nxt[SHROT_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/shrot_rr_arb.sv
// Requester arbiter: round-robin from ptr by default, lowest-index-wins
// fixed priority when SHROT_SCHED_FIXED_PRIO_EN is defined (no ptr port then).
module shrot_rr_arb
  import shrot_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]        req_valid,
`ifndef SHROT_SCHED_FIXED_PRIO_EN
  input  logic [SHROT_IDX_W-1:0] ptr,
`endif
  output logic [NREQ-1:0]        grant,
  output logic [SHROT_IDX_W-1:0] win_idx,
  output logic                   any_valid
);

`ifdef SHROT_SCHED_FIXED_PRIO_EN
  always_comb begin
    grant     = '0;
    win_idx   = '0;
    any_valid = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!any_valid && req_valid[k]) begin
        any_valid = 1'b1;
        grant[k]  = 1'b1;
        win_idx   = k[SHROT_IDX_W-1:0];
      end
    end
  end
`else
  always_comb begin
    int unsigned idx;
    grant     = '0;
    win_idx   = '0;
    any_valid = 1'b0;
    idx       = 0;
    // search ptr, ptr+1, ... wrapping; first valid requester wins
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!any_valid && req_valid[idx]) begin
        any_valid    = 1'b1;
        grant[idx]   = 1'b1;
        win_idx      = idx[SHROT_IDX_W-1:0];
      end
    end
  end
`endif

endmodule

// File: rtl/shrot_sched.sv
// Shares one 32-bit right-shift/rotate unit among NREQ requesters.
// Define SHROT_SCHED_FIXED_PRIO_EN for fixed priority instead of round-robin.
module shrot_sched
  import shrot_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int SH_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [SHROT_W*NREQ-1:0]   req_data,
  input  logic [SHROT_SEL_W*NREQ-1:0] req_select,
  input  logic [NREQ-1:0]           req_rotate,
  output logic [NREQ-1:0]           rsp_valid,
  input  logic [NREQ-1:0]           rsp_ready,
  output logic [SHROT_W-1:0]        rsp_data,
  output logic [SHROT_W-1:0]        sh_in,
  output logic [SHROT_SEL_W-1:0]    sh_select,
  output logic                      sh_rotate,
  input  logic [SHROT_W-1:0]        sh_out,
  output logic                      busy
);

  state_e                 state_q, state_d;
  logic [SHROT_IDX_W-1:0] op_idx_q, op_idx_d;
  logic [SHROT_W-1:0]     op_data_q, op_data_d;
  logic [SHROT_SEL_W-1:0] op_sel_q, op_sel_d;
  logic                   op_rot_q, op_rot_d;
  logic [SHROT_CNT_W-1:0] cnt_q, cnt_d;
  logic [SHROT_W-1:0]     rsp_data_q, rsp_data_d;

  logic [NREQ-1:0]        grant;
  logic [SHROT_IDX_W-1:0] win_idx;
  logic                   any_valid;
  logic                   owner_ready;

`ifndef SHROT_SCHED_FIXED_PRIO_EN
  logic [SHROT_IDX_W-1:0] ptr_q, ptr_d;
`endif

  shrot_rr_arb #(.NREQ(NREQ)) u_arb (
    .req_valid (req_valid),
`ifndef SHROT_SCHED_FIXED_PRIO_EN
    .ptr       (ptr_q),
`endif
    .grant     (grant),
    .win_idx   (win_idx),
    .any_valid (any_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_idx_q   <= '0;
      op_data_q  <= '0;
      op_sel_q   <= '0;
      op_rot_q   <= 1'b0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
`ifndef SHROT_SCHED_FIXED_PRIO_EN
      ptr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      op_idx_q   <= op_idx_d;
      op_data_q  <= op_data_d;
      op_sel_q   <= op_sel_d;
      op_rot_q   <= op_rot_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
`ifndef SHROT_SCHED_FIXED_PRIO_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  // Response outputs and the owner's handshake, decoded from op_idx_q.
  always_comb begin
    rsp_valid   = '0;
    owner_ready = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (state_q == ST_RESP && op_idx_q == k[SHROT_IDX_W-1:0]) begin
        rsp_valid[k] = 1'b1;
        owner_ready  = rsp_ready[k];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    op_idx_d   = op_idx_q;
    op_data_d  = op_data_q;
    op_sel_d   = op_sel_q;
    op_rot_d   = op_rot_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
`ifndef SHROT_SCHED_FIXED_PRIO_EN
    ptr_d      = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          op_idx_d = win_idx;
          for (int unsigned k = 0; k < NREQ; k++) begin
            if (grant[k]) begin
              op_data_d = req_data[SHROT_W*k +: SHROT_W];
              op_sel_d  = req_select[SHROT_SEL_W*k +: SHROT_SEL_W];
              op_rot_d  = req_rotate[k];
            end
          end
          cnt_d   = SHROT_CNT_W'(SH_LAT);
`ifndef SHROT_SCHED_FIXED_PRIO_EN
          ptr_d   = wrap_inc(win_idx, NREQ);
`endif
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - SHROT_CNT_W'(1);
        if (cnt_q == SHROT_CNT_W'(1)) begin
          rsp_data_d = sh_out;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (owner_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // rst_n gate keeps req_ready low while reset is asserted even with requests pending
  assign req_ready = (state_q == ST_IDLE && rst_n) ? grant : '0;
  assign rsp_data  = rsp_data_q;
  assign sh_in     = op_data_q;
  assign sh_select = op_sel_q;
  assign sh_rotate = op_rot_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shrot_sched.sv
// Directed self-checking bench for shrot_sched (SH_LAT=1 and SH_LAT=3 instances).
module tb_shrot_sched;

  logic        clk, rst_n;
  int          cyc;
  int          checks, errors;

  logic [1:0]  req_valid, req_ready, req_rotate, rsp_valid, rsp_ready;
  logic [63:0] req_data;
  logic [9:0]  req_select;
  logic [31:0] rsp_data, sh_in, sh_out;
  logic [4:0]  sh_select;
  logic        sh_rotate, busy;

  logic [1:0]  req_valid3, req_ready3, req_rotate3, rsp_valid3, rsp_ready3;
  logic [63:0] req_data3;
  logic [9:0]  req_select3;
  logic [31:0] rsp_data3, sh_in3, sh_out3, pipe1, pipe2;
  logic [4:0]  sh_select3;
  logic        sh_rotate3, busy3;

  function automatic logic [31:0] shrot_f(input logic [31:0] d, input logic [4:0] s, input logic r);
    logic [63:0] dd;
    dd = {d, d} >> s;
    return r ? dd[31:0] : (d >> s);
  endfunction

  shrot_sched #(.NREQ(2), .SH_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_select(req_select), .req_rotate(req_rotate),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .sh_in(sh_in), .sh_select(sh_select), .sh_rotate(sh_rotate),
    .sh_out(sh_out), .busy(busy)
  );

  shrot_sched #(.NREQ(2), .SH_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_data(req_data3), .req_select(req_select3), .req_rotate(req_rotate3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3),
    .sh_in(sh_in3), .sh_select(sh_select3), .sh_rotate(sh_rotate3),
    .sh_out(sh_out3), .busy(busy3)
  );

  // SH_LAT=1 shifter settles within the WAIT cycle; SH_LAT=3 shifter has two register stages
  assign sh_out = shrot_f(sh_in, sh_select, sh_rotate);
  always @(posedge clk) begin
    pipe1 <= shrot_f(sh_in3, sh_select3, sh_rotate3);
    pipe2 <= pipe1;
  end
  assign sh_out3 = pipe2;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic do_op(input int idx, input logic [31:0] d, input logic [4:0] s, input logic r,
                       output int t_acc, output int t_rsp, output logic [31:0] rd,
                       output logic [1:0] rv, output logic ok);
    bit found;
    int n;
    ok = 1'b0; t_acc = -1; t_rsp = -1; rd = '0; rv = '0;
    rsp_ready = 2'b11;
    req_data[32*idx +: 32] = d;
    req_select[5*idx +: 5] = s;
    req_rotate[idx]        = r;
    req_valid[idx]         = 1'b1;
    found = 0; n = 0;
    while (!found && n < 20) begin
      #1;
      if (req_ready[idx]) begin found = 1; t_acc = cyc; end
      @(negedge clk); n++;
    end
    req_valid[idx] = 1'b0;
    if (!found) return;
    found = 0; n = 0;
    while (!found && n < 20) begin
      #1;
      if (rsp_valid[idx]) begin found = 1; t_rsp = cyc; rd = rsp_data; rv = rsp_valid; end
      @(negedge clk); n++;
    end
    ok = found;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b want 00", rsp_valid); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
    checks++; if ({sh_in, sh_select, sh_rotate, rsp_data} !== 70'd0) begin
      errors++; $display("FAIL reset_regs got sh_in %h sel %h rot %b rsp %h want 0", sh_in, sh_select, sh_rotate, rsp_data);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_shift;
    int ta, tr; logic [31:0] rd; logic [1:0] rv; logic ok;
    do_op(0, 32'hF0000001, 5'd25, 1'b0, ta, tr, rd, rv, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL shift_timeout got %b want 1", ok); end
    checks++; if (tr - ta !== 2) begin errors++; $display("FAIL shift_latency got %0d want 2", tr - ta); end
    checks++; if (rd !== 32'h00000078) begin errors++; $display("FAIL shift_data got %h want 00000078", rd); end
    checks++; if (rv !== 2'b01) begin errors++; $display("FAIL shift_rsp_valid got %b want 01", rv); end
    checks++; if (sh_in !== 32'hF0000001 || sh_select !== 5'd25) begin
      errors++; $display("FAIL shift_sh_hold got %h/%0d want F0000001/25", sh_in, sh_select);
    end
  endtask

  task automatic test_single_rotate;
    logic [31:0] din [4]  = '{32'hF0000001, 32'hF0000001, 32'hF0000001, 32'h80000000};
    logic [4:0]  sel [4]  = '{5'd25, 5'd0, 5'd0, 5'd31};
    logic        rot [4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    int          who [4]  = '{0, 0, 0, 1};
    logic [31:0] exp_d [4] = '{32'h000000F8, 32'hF0000001, 32'hF0000001, 32'h00000001};
    int ta, tr; logic [31:0] rd; logic [1:0] rv; logic ok;
    for (int i = 0; i < 4; i++) begin
      do_op(who[i], din[i], sel[i], rot[i], ta, tr, rd, rv, ok);
      checks++; if (ok !== 1'b1 || rd !== exp_d[i]) begin
        errors++; $display("FAIL rotate_vec%0d got %h ok %b want %h", i, rd, ok, exp_d[i]);
      end
      checks++; if (rv !== (2'b01 << who[i])) begin
        errors++; $display("FAIL rotate_owner%0d got %b want %b", i, rv, 2'b01 << who[i]);
      end
    end
  endtask

  task automatic test_contention;
    int t [4]; int w [4]; int g, n;
    int exp_w [4];
`ifdef SHROT_SCHED_FIXED_PRIO_EN
    exp_w = '{0, 0, 0, 0};
`else
    exp_w = '{0, 1, 0, 1};
`endif
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_data = {32'h0000FFFF, 32'hFFFF0000};
    req_select = {5'd4, 5'd4};
    req_rotate = 2'b00;
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    g = 0; n = 0;
    while (g < 4 && n < 60) begin
      #1;
      if ((req_ready & req_valid) != 2'b00) begin
        t[g] = cyc;
        w[g] = req_ready[1] ? 1 : 0;
        g++;
      end
      @(negedge clk); n++;
    end
    req_valid = 2'b00;
    checks++; if (g !== 4) begin errors++; $display("FAIL contention_grants got %0d want 4", g); end
    for (int i = 0; i < g; i++) begin
      checks++; if (w[i] !== exp_w[i]) begin
        errors++; $display("FAIL contention_winner%0d got %0d want %0d", i, w[i], exp_w[i]);
      end
      if (i > 0) begin
        checks++; if (t[i] - t[i-1] !== 3) begin
          errors++; $display("FAIL contention_spacing%0d got %0d want 3", i, t[i] - t[i-1]);
        end
      end
    end
    n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL contention_drain got %b want 0", busy); end
  endtask

  task automatic test_backpressure;
    int n; bit found;
    rsp_ready = 2'b10;
    req_data[31:0] = 32'h12345678;
    req_select[4:0] = 5'd4;
    req_rotate[0] = 1'b1;
    req_valid = 2'b01;
    found = 0; n = 0;
    while (!found && n < 20) begin
      #1;
      if (req_ready[0]) found = 1;
      @(negedge clk); n++;
    end
    req_valid = 2'b00;
    n = 0;
    while (!rsp_valid[0] && n < 20) begin @(negedge clk); #1; n++; end
    req_valid = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (rsp_valid !== 2'b01 || rsp_data !== 32'h81234567) begin
        errors++; $display("FAIL bp_hold%0d got %b/%h want 01/81234567", i, rsp_valid, rsp_data);
      end
      checks++; if (req_ready !== 2'b00 || busy !== 1'b1) begin
        errors++; $display("FAIL bp_idle%0d got ready %b busy %b want 00/1", i, req_ready, busy);
      end
      @(negedge clk);
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0 || rsp_valid !== 2'b00 || req_ready !== 2'b10) begin
      errors++; $display("FAIL bp_release got busy %b rv %b ready %b want 0/00/10", busy, rsp_valid, req_ready);
    end
    req_valid = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op;
    int n; bit found;
    rsp_ready = 2'b11;
    req_data = {32'h11111111, 32'hDEADBEEF};
    req_select = {5'd1, 5'd8};
    req_rotate = 2'b00;
    req_valid = 2'b01;
    found = 0; n = 0;
    while (!found && n < 20) begin
      #1;
      if (req_ready[0]) found = 1;
      @(negedge clk); n++;
    end
    req_valid = 2'b11;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, rsp_valid, req_ready} !== 5'd0) begin
      errors++; $display("FAIL midrst_ctrl got busy %b rv %b ready %b want 0", busy, rsp_valid, req_ready);
    end
    checks++; if ({sh_in, sh_select, sh_rotate, rsp_data} !== 70'd0) begin
      errors++; $display("FAIL midrst_regs got sh_in %h sel %h rot %b rsp %h want 0", sh_in, sh_select, sh_rotate, rsp_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin
      errors++; $display("FAIL midrst_first_grant got %b want 01", req_ready);
    end
    @(negedge clk);
    req_valid = 2'b00;
    n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end
  endtask

  task automatic test_latency_sweep;
    logic [31:0] din [2]   = '{32'hAAAA0000, 32'h0000FF00};
    logic [4:0]  sel [2]   = '{5'd16, 5'd8};
    logic [31:0] exp_d [2] = '{32'h0000AAAA, 32'h000000FF};
    int ta, tr, n; bit found;
    rsp_ready3 = 2'b11;
    for (int i = 0; i < 2; i++) begin
      req_data3[31:0] = din[i];
      req_select3[4:0] = sel[i];
      req_rotate3[0] = 1'b0;
      req_valid3 = 2'b01;
      found = 0; n = 0; ta = -1; tr = -1;
      while (!found && n < 20) begin
        #1;
        if (req_ready3[0]) begin found = 1; ta = cyc; end
        @(negedge clk); n++;
      end
      req_valid3 = 2'b00;
      found = 0; n = 0;
      while (!found && n < 20) begin
        #1;
        if (rsp_valid3[0]) begin found = 1; tr = cyc; end
        else @(negedge clk);
        n++;
      end
      checks++; if (tr - ta !== 4) begin
        errors++; $display("FAIL lat3_timing%0d got %0d want 4", i, tr - ta);
      end
      checks++; if (rsp_data3 !== exp_d[i]) begin
        errors++; $display("FAIL lat3_data%0d got %h want %h", i, rsp_data3, exp_d[i]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    cyc = 0; checks = 0; errors = 0;
    rst_n = 1'b1;
    req_valid = '0; req_data = '0; req_select = '0; req_rotate = '0; rsp_ready = '0;
    req_valid3 = '0; req_data3 = '0; req_select3 = '0; req_rotate3 = '0; rsp_ready3 = '0;
    @(negedge clk);
    test_reset;
    test_single_shift;
    test_single_rotate;
    test_contention;
    test_backpressure;
    test_reset_mid_op;
    test_latency_sweep;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
